// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the data-memory responder.
// Optional misalign checking is enabled by DMEM_MISALIGN_CHECK_EN.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  function automatic logic [3:0] byte_en(
    input logic [1:0] size,
    input logic [1:0] lo
  );
    logic [3:0] be;
    be = 4'b1111;
    unique case (1'b1)
      (size == SZ_BYTE): be = 4'b0001 << lo;
      (size == SZ_HALF): be = lo[1] ? 4'b1100 : 4'b0011;
      default:           be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic is_misaligned(
    input logic [1:0] size,
    input logic [1:0] lo
  );
    logic bad;
    bad = 1'b0;
    unique case (1'b1)
      (size == SZ_HALF): bad = lo[0];
      (size == SZ_WORD): bad = (lo != 2'b00);
      (size == SZ_RSVD): bad = 1'b1;
      default:           bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store replication/enables, load extension.
// DMEM_MISALIGN_CHECK_EN turns on the misalign flag.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lo,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [31:0] wdata_rep,
  output logic [3:0]  be,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [7:0]  b_sel;
  logic [15:0] h_sel;

  assign be    = byte_en(size, lo);
  assign b_sel = rword[{lo, 3'b000} +: 8];
  assign h_sel = lo[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    wdata_rep = wdata;
    unique case (1'b1)
      (size == SZ_BYTE): wdata_rep = {4{wdata[7:0]}};
      (size == SZ_HALF): wdata_rep = {2{wdata[15:0]}};
      default:           wdata_rep = wdata;
    endcase
  end

  always_comb begin
    rdata_ext = rword;
    unique case (1'b1)
      (size == SZ_BYTE):
        rdata_ext = uns ? {24'h0, b_sel}
                        : {{24{b_sel[7]}}, b_sel};
      (size == SZ_HALF):
        rdata_ext = uns ? {16'h0, h_sel}
                        : {{16{h_sel[15]}}, h_sel};
      default:
        rdata_ext = rword;
    endcase
  end

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misalign = is_misaligned(size, lo);
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: rtl/data_mem_responder.sv
// Stallable data memory: one request at a time, WAIT_CYCLES wait states.
// DMEM_MISALIGN_CHECK_EN rejects misaligned/reserved-size requests.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        commit;
  logic        cur_we;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [1:0]  cur_size;
  logic        cur_uns;
  logic [AW-1:0] idx;
  logic [31:0] rword;
  logic [31:0] wdata_rep;
  logic [3:0]  be;
  logic [31:0] rdata_ext;
  logic        misalign;
  logic        mem_we;
  logic        unused_hi;

  logic [31:0] mem [DEPTH];

  // With zero wait states the commit edge is the accept edge.
  assign cur_we    = (state_q == ST_IDLE) ? req_we       : we_q;
  assign cur_addr  = (state_q == ST_IDLE) ? req_addr     : addr_q;
  assign cur_wdata = (state_q == ST_IDLE) ? req_wdata    : wdata_q;
  assign cur_size  = (state_q == ST_IDLE) ? req_size     : size_q;
  assign cur_uns   = (state_q == ST_IDLE) ? req_unsigned : uns_q;

  assign idx       = cur_addr[AW+1:2];
  assign rword     = mem[idx];
  assign unused_hi = ^{cur_addr[31:AW+2]};

  dmem_lane_align u_align (
    .size      (cur_size),
    .lo        (cur_addr[1:0]),
    .uns       (cur_uns),
    .wdata     (cur_wdata),
    .rword     (rword),
    .wdata_rep (wdata_rep),
    .be        (be),
    .rdata_ext (rdata_ext),
    .misalign  (misalign)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    size_d    = size_q;
    uns_d     = uns_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    commit    = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          size_d  = req_size;
          uns_d   = req_unsigned;
          if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end else begin
            state_d = ST_RESP;
            commit  = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (commit) begin
      rdata_d = (cur_we || misalign) ? 32'h0 : rdata_ext;
      err_d   = misalign;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array is deliberately unreset; stores never land while in reset.
  assign mem_we = commit && cur_we && !misalign && reset;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_we && be[i]) begin
        mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: WAIT_CYCLES=1 and WAIT_CYCLES=4 instances share one bus.
// Expectations switch on DMEM_MISALIGN_CHECK_EN.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        rsp_ready;

  logic        req_ready1, rsp_valid1, rsp_err1;
  logic [31:0] rsp_rdata1;
  logic        req_ready4, rsp_valid4, rsp_err4;
  logic [31:0] rsp_rdata4;

  int checks = 0;
  int errors = 0;

  logic [31:0] rd1, rd4;
  logic        er1, er4;

`ifdef DMEM_MISALIGN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready1),
    .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
  );

  data_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(4)) u_dut4 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready4),
    .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata4), .rsp_err(rsp_err4)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic [1:0] sz,
                       input logic uns);
    req_valid    = 1'b1;
    req_we       = we;
    req_addr     = a;
    req_wdata    = d;
    req_size     = sz;
    req_unsigned = uns;
  endtask

  // Called just after the accept edge; scrambles the bus to prove
  // the request was latched, then waits for both responses.
  task automatic collect(input string tag);
    int lat = 1;
    bit g1 = 0;
    bit g4 = 0;
    int l1 = 0;
    int l4 = 0;
    req_valid = 1'b0;
    req_addr  = ~req_addr;
    req_wdata = 32'h5A5A_A5A5;
    req_we    = ~req_we;
    for (int i = 0; i < 30 && !(g1 && g4); i++) begin
      if (!g1 && rsp_valid1) begin
        g1 = 1; l1 = lat; rd1 = rsp_rdata1; er1 = rsp_err1;
      end
      if (!g4 && rsp_valid4) begin
        g4 = 1; l4 = lat; rd4 = rsp_rdata4; er4 = rsp_err4;
      end
      if (!(g1 && g4)) begin
        tick();
        lat++;
      end
    end
    check({tag, "_seen1"}, 32'(g1), 32'd1);
    check({tag, "_seen4"}, 32'(g4), 32'd1);
    check({tag, "_lat1"}, l1, 32'd2);
    check({tag, "_lat4"}, l4, 32'd5);
    tick();
  endtask

  task automatic xact(input string tag, input logic we,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] sz, input logic uns);
    drive(we, a, d, sz, uns);
    tick();
    collect(tag);
  endtask

  initial begin
    reset        = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    rsp_ready    = 1'b1;
    tick();
    tick();
    check("rst_req_ready", 32'(req_ready1), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid1), 32'd0);
    check("rst_rdata", rsp_rdata1, 32'h0);
    check("rst_err", 32'(rsp_err1), 32'd0);
    reset = 1'b1;
    tick();

    xact("sw100", 1, 32'h100, 32'hDEADBEEF, 2'b10, 0);
    check("sw100_rd", rd1, 32'h0);
    xact("lw100", 0, 32'h100, 32'h0, 2'b10, 0);
    check("lw100_rd1", rd1, 32'hDEADBEEF);
    check("lw100_rd4", rd4, 32'hDEADBEEF);
    xact("lwwrap", 0, 32'h1100, 32'h0, 2'b10, 0);
    check("lwwrap_rd", rd1, 32'hDEADBEEF);

    xact("sw200", 1, 32'h200, 32'h000080F0, 2'b10, 0);
    xact("lb200", 0, 32'h200, 32'h0, 2'b00, 0);
    check("lb200_rd", rd1, 32'hFFFFFFF0);
    xact("lbu200", 0, 32'h200, 32'h0, 2'b00, 1);
    check("lbu200_rd", rd1, 32'h000000F0);
    xact("lb201", 0, 32'h201, 32'h0, 2'b00, 0);
    check("lb201_rd", rd1, 32'hFFFFFF80);
    xact("lh202", 0, 32'h202, 32'h0, 2'b01, 0);
    check("lh202_rd", rd1, 32'h00000000);
    xact("lh200", 0, 32'h200, 32'h0, 2'b01, 0);
    check("lh200_rd", rd1, 32'hFFFF80F0);
    xact("lhu200", 0, 32'h200, 32'h0, 2'b01, 1);
    check("lhu200_rd", rd1, 32'h000080F0);

    xact("sw300", 1, 32'h300, 32'h11223344, 2'b10, 0);
    xact("sb301", 1, 32'h301, 32'h123456AA, 2'b00, 0);
    xact("sh302", 1, 32'h302, 32'h9999BEEF, 2'b01, 0);
    xact("lw300", 0, 32'h300, 32'h0, 2'b10, 0);
    check("lw300_rd1", rd1, 32'hBEEFAA44);
    check("lw300_rd4", rd4, 32'hBEEFAA44);

    // Backpressure with a second request held pending.
    rsp_ready = 1'b0;
    drive(0, 32'h300, 32'h0, 2'b10, 0);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 20 && !rsp_valid4; i++) tick();
    check("bp_valid4", 32'(rsp_valid4), 32'd1);
    drive(0, 32'h100, 32'h0, 2'b10, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", 32'(rsp_valid1), 32'd1);
      check("bp_rdata", rsp_rdata1, 32'hBEEFAA44);
      check("bp_ready", 32'(req_ready1), 32'd0);
      check("bp_rdata4", rsp_rdata4, 32'hBEEFAA44);
    end
    rsp_ready = 1'b1;
    tick();
    check("hs_ready", 32'(req_ready1), 32'd1);
    check("hs_valid", 32'(rsp_valid1), 32'd0);
    check("hs_ready4", 32'(req_ready4), 32'd1);
    tick();
    check("acc_ready", 32'(req_ready1), 32'd0);
    collect("bp2");
    check("bp2_rd", rd1, 32'hDEADBEEF);

    // Misaligned word store and reserved size.
    xact("swmis", 1, 32'h102, 32'hCAFEF00D, 2'b10, 0);
    check("swmis_err", 32'(er1), 32'(CHK));
    check("swmis_rd", rd1, 32'h0);
    xact("lwmis", 0, 32'h100, 32'h0, 2'b10, 0);
    check("lwmis_rd", rd1, CHK ? 32'hDEADBEEF : 32'hCAFEF00D);
    check("lwmis_err", 32'(er1), 32'd0);
    xact("sw104", 1, 32'h104, 32'h0BADF00D, 2'b10, 0);
    xact("srsv", 1, 32'h104, 32'h01020304, 2'b11, 0);
    check("srsv_err", 32'(er4), 32'(CHK));
    xact("lw104", 0, 32'h104, 32'h0, 2'b10, 0);
    check("lw104_rd", rd1, CHK ? 32'h0BADF00D : 32'h01020304);

    // Reset lands in the 2nd wait cycle of the WAIT_CYCLES=4 unit.
    xact("sw400", 1, 32'h400, 32'h12345678, 2'b10, 0);
    xact("lw400a", 0, 32'h400, 32'h0, 2'b10, 0);
    check("lw400a_rd4", rd4, 32'h12345678);
    drive(1, 32'h400, 32'h55, 2'b00, 0);
    tick();
    req_valid = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    check("mr_ready4", 32'(req_ready4), 32'd1);
    check("mr_valid4", 32'(rsp_valid4), 32'd0);
    check("mr_rdata4", rsp_rdata4, 32'h0);
    check("mr_err4", 32'(rsp_err4), 32'd0);
    check("mr_valid1", 32'(rsp_valid1), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    xact("lw400b", 0, 32'h400, 32'h0, 2'b10, 0);
    check("lw400b_rd4", rd4, 32'h12345678);
    check("lw400b_rd1", rd1, 32'h12345655);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
